// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI master controller.
//   spi_ctrl_state_e   : controller FSM states
//   DEFAULT_DATA_WIDTH : default bits per transfer
//   idx_width()        : width of the slave-index field (at least 1 bit)
//   xfer_latency()     : pclk cycles from request accept to rsp_valid
package spi_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} spi_ctrl_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned xfer_latency(input int unsigned data_width,
                                               input int unsigned div);
    return (2 * data_width + 2) * (div + 1) + 1;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Request/response handshake, configuration and SPI pins of the SPI master.
//   master modport : controller view (config/request/miso in; ready/response/SPI pins out)
//   slave  modport : requester/slave-agent view (directions reversed)
interface spi_master_ctrl_if
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned NO_OF_SLAVES = 1,
  parameter int unsigned DIV_W        = 8
) ();
  localparam int unsigned IDX_W = idx_width(NO_OF_SLAVES);

  logic                    cfg_cpol;
  logic                    cfg_cpha;
  logic [DIV_W-1:0]        cfg_clk_div;
  logic                    req_valid;
  logic                    req_ready;
  logic [IDX_W-1:0]        req_cs_idx;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    busy;
  logic                    sclk;
  logic [NO_OF_SLAVES-1:0] cs_n;
  logic                    mosi0;
  logic                    miso0;

  modport master (
    input  cfg_cpol, cfg_cpha, cfg_clk_div, req_valid, req_cs_idx, req_data, miso0,
    output req_ready, rsp_valid, rsp_data, busy, sclk, cs_n, mosi0
  );

  modport slave (
    output cfg_cpol, cfg_cpha, cfg_clk_div, req_valid, req_cs_idx, req_data, miso0,
    input  req_ready, rsp_valid, rsp_data, busy, sclk, cs_n, mosi0
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count while high; held at zero otherwise
//   clr        : restart the half-period from zero
//   div        : half-period length minus one, in clk cycles
//   tick       : one-cycle pulse at the end of each half-period
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == div)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == div);
endmodule

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master, all four CPOL/CPHA modes, MSB first.
//   pclk, areset_n : clock, asynchronous active-low reset
//   bus (master)   : cfg_cpol/cfg_cpha/cfg_clk_div, req_valid/req_ready/req_cs_idx/req_data,
//                    rsp_valid/rsp_data, busy, sclk, cs_n, mosi0, miso0
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned NO_OF_SLAVES = 1,
  parameter int unsigned DIV_W        = 8
) (
  input logic              pclk,
  input logic              areset_n,
  spi_master_ctrl_if.master bus
);
  localparam int unsigned IDX_W  = idx_width(NO_OF_SLAVES);
  localparam int unsigned ECNT_W = $clog2(2 * DATA_WIDTH + 1);

  spi_ctrl_state_e         state, state_nxt;
  logic                    accept, tick, timer_en;
  logic                    cpha_q, sclk_q, mosi_q;
  logic [DIV_W-1:0]        div_q;
  logic [DATA_WIDTH-1:0]   tx_q, rx_q, rsp_data_q;
  logic [NO_OF_SLAVES-1:0] cs_n_q, cs_sel;
  logic [ECNT_W-1:0]       edge_cnt;
  logic                    leading, last_edge, sample_edge, shift_edge;

  assign accept   = bus.req_valid && (state == IDLE);
  assign timer_en = (state == SETUP) || (state == XFER) || (state == HOLD);

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk   (pclk),
    .rst_n (areset_n),
    .en    (timer_en),
    .clr   (accept),
    .div   (div_q),
    .tick  (tick)
  );

  // edge_cnt holds completed ticks, so an even count means the coming tick is odd (leading)
  assign leading     = ~edge_cnt[0];
  assign last_edge   = (edge_cnt == ECNT_W'(2 * DATA_WIDTH - 1));
  assign sample_edge = cpha_q ? ~leading : leading;
  assign shift_edge  = cpha_q ? leading : (~leading && ~last_edge);

  always_comb begin
    cs_sel = '1;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
      if (bus.req_cs_idx == IDX_W'(i)) cs_sel[i] = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid)       state_nxt = SETUP;
      SETUP:   if (tick)                state_nxt = XFER;
      XFER:    if (tick && last_edge)   state_nxt = HOLD;
      HOLD:    if (tick)                state_nxt = DONE;
      DONE:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge areset_n) begin
    if (!areset_n) begin
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      div_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      cs_n_q     <= '1;
      edge_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          cpha_q   <= bus.cfg_cpha;
          div_q    <= bus.cfg_clk_div;
          sclk_q   <= bus.cfg_cpol;
          cs_n_q   <= cs_sel;
          rx_q     <= '0;
          edge_cnt <= '0;
          // cpha=0 presents the MSB before the first edge; tx_q then holds the remaining bits
          if (bus.cfg_cpha) begin
            mosi_q <= 1'b0;
            tx_q   <= bus.req_data;
          end else begin
            mosi_q <= bus.req_data[DATA_WIDTH-1];
            tx_q   <= bus.req_data << 1;
          end
        end
        XFER: if (tick) begin
          sclk_q   <= ~sclk_q;
          edge_cnt <= edge_cnt + ECNT_W'(1);
          if (sample_edge) rx_q <= {rx_q[DATA_WIDTH-2:0], bus.miso0};
          if (shift_edge) begin
            mosi_q <= tx_q[DATA_WIDTH-1];
            tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        HOLD: if (tick) begin
          cs_n_q     <= '1;
          rsp_data_q <= rx_q;
        end
        DONE: mosi_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.sclk      = (state == IDLE) ? bus.cfg_cpol : sclk_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.mosi0     = mosi_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a mode-aware SPI slave model.
module tb_spi_master_ctrl;
  localparam int unsigned DW   = 8;
  localparam int unsigned NS   = 3;
  localparam int unsigned DIVW = 8;

  logic pclk     = 1'b0;
  logic areset_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  spi_master_ctrl_if #(.DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .DIV_W(DIVW)) bus ();

  spi_master_ctrl #(.DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .DIV_W(DIVW)) dut (
    .pclk     (pclk),
    .areset_n (areset_n),
    .bus      (bus.master)
  );

  always #5 pclk = ~pclk;

  // Slave model: samples mosi0 and shifts miso0 on SCLK edges according to its own mode.
  logic       slv_active = 1'b0;
  logic       slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lead_seen = 1'b0;
  logic [7:0] slv_sr = '0, slv_rx = '0;
  logic [2:0] cs_seen = '1;
  int         sclk_edges = 0;

  assign bus.miso0 = slv_sr[7];

  always @(bus.sclk) begin
    if (slv_active) begin
      sclk_edges++;
      if (sclk_edges == 1) cs_seen = bus.cs_n;
      if (bus.sclk !== slv_cpol) begin
        if (!slv_cpha) slv_rx = {slv_rx[6:0], bus.mosi0};
        else begin
          if (slv_lead_seen) slv_sr = slv_sr << 1;
          slv_lead_seen = 1'b1;
        end
      end else begin
        if (slv_cpha) slv_rx = {slv_rx[6:0], bus.mosi0};
        else          slv_sr = slv_sr << 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge of the IDLE cycle after rsp_valid.
  task automatic do_xfer(input string tag, input logic cpol, input logic cpha,
                         input logic [7:0] div, input logic [1:0] idx,
                         input logic [7:0] data, input logic [7:0] word,
                         input int exp_lat, input logic hold);
    int n, lat;
    logic [2:0] exp_cs;
    exp_cs = (idx == 2'd0) ? 3'b110 : (idx == 2'd1) ? 3'b101 :
             (idx == 2'd2) ? 3'b011 : 3'b111;
    bus.cfg_cpol = cpol; bus.cfg_cpha = cpha; bus.cfg_clk_div = div;
    bus.req_cs_idx = idx; bus.req_data = data; bus.req_valid = 1'b1;
    slv_active = 1'b0; slv_cpol = cpol; slv_cpha = cpha; slv_lead_seen = 1'b0;
    slv_sr = word; slv_rx = '0; sclk_edges = 0; cs_seen = '1;
    #1;
    check({tag, "_idle_sclk"}, bus.sclk, cpol);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge pclk); n++; end
    check({tag, "_accept_wait"}, n, 0);
    @(posedge pclk); #1;
    if (!hold) bus.req_valid = 1'b0;
    slv_active = 1'b1;
    lat = 0;
    while (!bus.rsp_valid && lat < 400) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) begin
        check({tag, "_busy"}, bus.busy, 1'b1);
        check({tag, "_cs_low"}, bus.cs_n, exp_cs);
      end
    end
    slv_active = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_data"}, bus.rsp_data, word);
    check({tag, "_sclk_edges"}, sclk_edges, 16);
    check({tag, "_mosi_word"}, slv_rx, data);
    check({tag, "_cs_seen"}, cs_seen, exp_cs);
    check({tag, "_done_ready"}, bus.req_ready, 1'b0);
    check({tag, "_done_cs"}, bus.cs_n, 3'b111);
    @(negedge pclk);
    check({tag, "_post_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_post_ready"}, bus.req_ready, 1'b1);
    check({tag, "_post_cs"}, bus.cs_n, 3'b111);
    check({tag, "_post_mosi"}, bus.mosi0, 1'b0);
    check({tag, "_post_sclk"}, bus.sclk, bus.cfg_cpol);
    check({tag, "_rsp_hold"}, bus.rsp_data, word);
  endtask

  initial begin
    int pulses;
    bus.cfg_cpol = 1'b0; bus.cfg_cpha = 1'b0; bus.cfg_clk_div = '0;
    bus.req_valid = 1'b0; bus.req_cs_idx = '0; bus.req_data = '0;
    #1 areset_n = 1'b0;
    repeat (2) @(negedge pclk);

    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cs", bus.cs_n, 3'b111);
    check("rst_mosi", bus.mosi0, 1'b0);
    check("rst_sclk0", bus.sclk, 1'b0);
    bus.cfg_cpol = 1'b1;
    #1 check("rst_sclk1", bus.sclk, 1'b1);
    bus.cfg_cpol = 1'b0;
    @(negedge pclk);
    areset_n = 1'b1;
    @(negedge pclk);

    do_xfer("mode0", 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 8'h3C, 19, 1'b0);

    do_xfer("mode1", 1'b0, 1'b1, 8'd3, 2'd0, 8'h81, 8'h5A, 73, 1'b0);
    do_xfer("mode2", 1'b1, 1'b0, 8'd3, 2'd0, 8'h81, 8'hC3, 73, 1'b0);
    do_xfer("mode3", 1'b1, 1'b1, 8'd3, 2'd0, 8'h81, 8'h96, 73, 1'b0);

    do_xfer("b2b_first", 1'b0, 1'b0, 8'd0, 2'd0, 8'h01, 8'hE7, 19, 1'b1);
    do_xfer("b2b_second", 1'b0, 1'b0, 8'd0, 2'd0, 8'hFE, 8'h18, 19, 1'b0);

    fork
      begin
        repeat (10) @(negedge pclk);
        bus.cfg_cpol = 1'b1;
        bus.cfg_clk_div = 8'd7;
      end
    join_none
    do_xfer("cfg_old", 1'b0, 1'b0, 8'd1, 2'd0, 8'hC4, 8'h2B, 37, 1'b0);
    do_xfer("cfg_new", 1'b1, 1'b0, 8'd7, 2'd0, 8'h3D, 8'hD2, 145, 1'b0);

    bus.cfg_cpol = 1'b0; bus.cfg_cpha = 1'b0; bus.cfg_clk_div = 8'd1;
    bus.req_cs_idx = 2'd0; bus.req_data = 8'h08; bus.req_valid = 1'b1;
    slv_sr = 8'h0F;
    @(posedge pclk); #1 bus.req_valid = 1'b0;
    repeat (20) @(negedge pclk);
    check("arst_pre_busy", bus.busy, 1'b1);
    check("arst_pre_cs", bus.cs_n, 3'b110);
    check("arst_pre_mosi", bus.mosi0, 1'b1);
    #2 areset_n = 1'b0;
    #1;
    check("arst_cs", bus.cs_n, 3'b111);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_ready", bus.req_ready, 1'b1);
    check("arst_rsp_valid", bus.rsp_valid, 1'b0);
    check("arst_mosi", bus.mosi0, 1'b0);
    check("arst_rsp_data", bus.rsp_data, 8'h00);
    check("arst_sclk", bus.sclk, 1'b0);
    repeat (2) @(negedge pclk);
    areset_n = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge pclk);
      if (bus.rsp_valid) pulses++;
    end
    check("arst_no_rsp", pulses, 0);
    do_xfer("arst_next", 1'b0, 1'b0, 8'd1, 2'd0, 8'hC9, 8'h6E, 37, 1'b0);

    do_xfer("cs_idx2", 1'b0, 1'b0, 8'd0, 2'd2, 8'h55, 8'hAA, 19, 1'b0);
    do_xfer("cs_idx_oob", 1'b0, 1'b0, 8'd0, 2'd3, 8'h33, 8'hF0, 19, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
